// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_ctrl
//  Purpose  : 640x480@60 VGA timing generator and pixel-fetch sequencer.
//             Issues per-pixel read requests (X/Y) to a 1-cycle-latency
//             pixel source, realigns the returned RGB565 with hsync/vsync
//             and blanks the output outside the active area. Start/stop
//             requests take effect only at frame boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10,
  parameter int CNT_W   = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic [15:0]      pix_data,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             busy,
  output logic             hsync,
  output logic             vsync,
  output logic [15:0]      rgb
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  // Counter-width constants so every compare is width-matched.
  localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_h_sync   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] c_v_sync   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] c_h_act_lo = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] c_h_act_hi = CNT_W'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CNT_W-1:0] c_v_act_lo = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] c_v_act_hi = CNT_W'(V_SYNC + V_BACK + V_VALID);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             busy_q;

  // Stage 1: registered straight from the counters.
  logic             req1_q;
  logic [CNT_W-1:0] x1_q, y1_q;
  logic             fs1_q, hs1_q, vs1_q;
  // Stage 2: sync and data-enable delayed to meet the returning pixel data.
  logic             hs2_q, vs2_q, de2_q;
  // Stage 3: outputs aligned with the registered RGB.
  logic             hs3_q, vs3_q;
  logic [15:0]      rgb_q;

  logic running, h_last, v_last, frame_end, active;

  assign running   = (state_q != ST_IDLE);
  assign h_last    = (h_cnt_q == c_h_last);
  assign v_last    = (v_cnt_q == c_v_last);
  assign frame_end = h_last && v_last;
  assign active    = running &&
                     (h_cnt_q >= c_h_act_lo) && (h_cnt_q < c_h_act_hi) &&
                     (v_cnt_q >= c_v_act_lo) && (v_cnt_q < c_v_act_hi);

  // Next-state and raster-counter logic; counters are parked at 0 in IDLE.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)             state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (running) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : (v_cnt_q + c_one);
      end else begin
        h_cnt_d = h_cnt_q + c_one;
      end
    end else begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end
  end

  // State, counters and busy flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Stage 1: request, coordinates, frame marker and raw syncs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      req1_q <= 1'b0;
      x1_q   <= '0;
      y1_q   <= '0;
      fs1_q  <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
    end else begin
      req1_q <= active;
      x1_q   <= active ? (h_cnt_q - c_h_act_lo) : '0;
      y1_q   <= active ? (v_cnt_q - c_v_act_lo) : '0;
      fs1_q  <= running && (h_cnt_q == '0) && (v_cnt_q == '0);
      hs1_q  <= running && (h_cnt_q < c_h_sync);
      vs1_q  <= running && (v_cnt_q < c_v_sync);
    end
  end

  // Stages 2 and 3: delay syncs by two cycles and capture the returned pixel.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      de2_q <= 1'b0;
      hs3_q <= 1'b0;
      vs3_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      de2_q <= req1_q;
      hs3_q <= hs2_q;
      vs3_q <= vs2_q;
      rgb_q <= de2_q ? pix_data : 16'd0;
    end
  end

  assign pix_req     = req1_q;
  assign pix_x       = x1_q;
  assign pix_y       = y1_q;
  assign frame_start = fs1_q;
  assign busy        = busy_q;
  assign hsync       = hs3_q;
  assign vsync       = vs3_q;
  assign rgb         = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_ctrl
//  Purpose  : Self-checking bench for vga_timing_ctrl using a reduced raster
//             (17x12) so complete frames fit in a short run. A cycle model
//             pushes expected stage-1 results into a two-deep queue and pops
//             them when the delayed outputs are due.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

  localparam int HS = 4, HB = 3, HV = 8, HF = 2;
  localparam int VS = 2, VB = 3, VV = 5, VF = 2;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] pix_data = 16'hDEAD;
  logic        pix_req;
  logic [9:0]  pix_x, pix_y;
  logic        frame_start, busy, hsync, vsync;
  logic [15:0] rgb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .CNT_W(10)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .en(en), .pix_data(pix_data),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .busy(busy),
    .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  // Pixel source: returns the requested column one cycle later, junk otherwise.
  always @(posedge clk) pix_data <= pix_req ? {6'd0, pix_x} : 16'hDEAD;

  logic [40:0] dut_vec;
  assign dut_vec = {pix_req, pix_x, pix_y, frame_start, busy, hsync, vsync, rgb};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       req;
    logic [9:0] x;
  } stg_t;

  stg_t        pipe[$];
  int          m_state = 0;   // 0 idle, 1 run, 2 drain
  int          m_h = 0, m_v = 0;
  logic        e_req = 0, e_fs = 0, e_busy = 0, e_hs = 0, e_vs = 0;
  logic [9:0]  e_x = 0, e_y = 0;
  logic [15:0] e_rgb = 0;

  function automatic logic [40:0] exp_vec();
    return {e_req, e_x, e_y, e_fs, e_busy, e_hs, e_vs, e_rgb};
  endfunction

  task automatic tick();
    bit   act;
    int   ns;
    stg_t s, o;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_h = 0; m_v = 0;
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      e_req = 0; e_x = 0; e_y = 0; e_fs = 0; e_busy = 0;
      e_hs = 0; e_vs = 0; e_rgb = 0;
    end else begin
      act = (m_state != 0) && (m_h >= HS + HB) && (m_h < HS + HB + HV) &&
            (m_v >= VS + VB) && (m_v < VS + VB + VV);
      e_req = act;
      e_x   = act ? 10'(m_h - (HS + HB)) : 10'd0;
      e_y   = act ? 10'(m_v - (VS + VB)) : 10'd0;
      e_fs  = (m_state != 0) && (m_h == 0) && (m_v == 0);
      s.hs  = (m_state != 0) && (m_h < HS);
      s.vs  = (m_state != 0) && (m_v < VS);
      s.req = act;
      s.x   = e_x;
      o = pipe.pop_front();
      pipe.push_back(s);
      e_hs  = o.hs;
      e_vs  = o.vs;
      e_rgb = o.req ? {6'd0, o.x} : 16'd0;
      case (m_state)
        0:       ns = en ? 1 : 0;
        1:       ns = en ? 1 : 2;
        default: ns = en ? 1 : ((m_h == HT - 1 && m_v == VT - 1) ? 0 : 2);
      endcase
      if (m_state != 0) begin
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
      end
      m_state = ns;
      e_busy  = (ns != 0);
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; en = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dut_vec !== 41'd0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, dut_vec);
      end
    end
    rst = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (frame_start !== (i == 2)) begin
        failures++;
        $display("FAIL reset_first_frame_start tick=%0d got=%b exp=%b", i, frame_start, (i == 2));
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL reset_release_vec tick=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_frame_timing();
    bit found = 0;
    int n_req = 0, n_hs = 0, n_vs = 0, first_req = -1, fs_at = -1, rgb_sum = 0;
    en = 1;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL timing_wait_vec got=%h exp=%h", dut_vec, exp_vec());
      end
      if (frame_start === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL timing_frame_start_timeout got=none exp=pulse");
    end
    for (int i = 1; i <= FRAME; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL timing_vec tick=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (pix_req === 1'b1) begin
        n_req++;
        if (first_req < 0) first_req = i;
      end
      if (hsync === 1'b1) n_hs++;
      if (vsync === 1'b1) n_vs++;
      if (frame_start === 1'b1 && fs_at < 0) fs_at = i;
      rgb_sum += int'(rgb);
      if (i == (VS + VB) * HT + HS + HB + 2 + HV - 1) begin
        checks++;
        if (rgb !== 16'(HV - 1)) begin
          failures++;
          $display("FAIL align_last_pixel got=%0d exp=%0d", rgb, HV - 1);
        end
      end
    end
    checks++;
    if (first_req != (VS + VB) * HT + HS + HB) begin
      failures++;
      $display("FAIL first_req_delay got=%0d exp=%0d", first_req, (VS + VB) * HT + HS + HB);
    end
    checks++;
    if (n_req != HV * VV) begin
      failures++;
      $display("FAIL req_count got=%0d exp=%0d", n_req, HV * VV);
    end
    checks++;
    if (n_hs != HS * VT) begin
      failures++;
      $display("FAIL hsync_count got=%0d exp=%0d", n_hs, HS * VT);
    end
    checks++;
    if (n_vs != VS * HT) begin
      failures++;
      $display("FAIL vsync_count got=%0d exp=%0d", n_vs, VS * HT);
    end
    checks++;
    if (fs_at != FRAME) begin
      failures++;
      $display("FAIL frame_period got=%0d exp=%0d", fs_at, FRAME);
    end
    checks++;
    if (rgb_sum != VV * HV * (HV - 1) / 2) begin
      failures++;
      $display("FAIL align_rgb_sum got=%0d exp=%0d", rgb_sum, VV * HV * (HV - 1) / 2);
    end
  endtask

  task automatic test_drain();
    bit found = 0;
    int fall = -1, stray = 0, n_req = 0;
    en = 1;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL drain_wait_vec got=%h exp=%h", dut_vec, exp_vec());
      end
      if (frame_start === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL drain_frame_start_timeout got=none exp=pulse");
    end
    for (int i = 0; i < 7 * HT; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL drain_pre_vec got=%h exp=%h", dut_vec, exp_vec());
      end
    end
    en = 0;
    for (int k = 1; k <= FRAME - 7 * HT - 1 + 20; k++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL drain_vec tick=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (busy === 1'b0 && fall < 0) fall = k;
      if (fall < 0 && pix_req === 1'b1) n_req++;
      if (fall > 0 && k > fall + 2 && (pix_req | hsync | vsync) !== 1'b0) stray++;
    end
    checks++;
    if (fall != FRAME - 7 * HT - 1) begin
      failures++;
      $display("FAIL drain_busy_fall got=%0d exp=%0d", fall, FRAME - 7 * HT - 1);
    end
    checks++;
    if (n_req != (VS + VB + VV - 7) * HV) begin
      failures++;
      $display("FAIL drain_req_count got=%0d exp=%0d", n_req, (VS + VB + VV - 7) * HV);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL drain_idle_activity got=%0d exp=0", stray);
    end
  endtask

  task automatic test_resume();
    bit found = 0;
    int fs_at = -1;
    en = 1;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL resume_wait_vec got=%h exp=%h", dut_vec, exp_vec());
      end
      if (frame_start === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL resume_frame_start_timeout got=none exp=pulse");
    end
    for (int i = 1; i <= 2 * FRAME && fs_at < 0; i++) begin
      if (i == 3 * HT + 1) en = 0;
      if (i == 6 * HT + 1) en = 1;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL resume_vec tick=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL resume_busy tick=%0d got=%b exp=1", i, busy);
      end
      if (frame_start === 1'b1) fs_at = i;
    end
    checks++;
    if (fs_at != FRAME) begin
      failures++;
      $display("FAIL resume_frame_period got=%0d exp=%0d", fs_at, FRAME);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    en = 1;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rstmid_wait_vec got=%h exp=%h", dut_vec, exp_vec());
      end
      if (e_rgb != 16'd0 && e_req) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rstmid_active_timeout got=none exp=active");
    end
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec !== 41'd0) begin
        failures++;
        $display("FAIL rstmid_outputs cyc=%0d got=%h exp=0", i, dut_vec);
      end
    end
    rst = 0;
    for (int i = 1; i <= FRAME + 2; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rstmid_restart_vec tick=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (i <= 4 || i == FRAME + 2) begin
        checks++;
        if (frame_start !== (i == 2 || i == FRAME + 2)) begin
          failures++;
          $display("FAIL rstmid_frame_start tick=%0d got=%b exp=%b", i, frame_start, (i == 2 || i == FRAME + 2));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_drain();
    test_resume();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
